// File: rtl/usb_uart_pkg.sv
// usb_uart_pkg: shared definitions for the USB UART OUT endpoint slice.
//   ep_state_t          - OUT endpoint FSM state encoding (2-bit)
//   USB_UART_FIFO_DEPTH - default receive FIFO depth
package usb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } ep_state_t;

    localparam int unsigned USB_UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/usb_uart_fifo.sv
// usb_uart_fifo: circular receive buffer between the OUT endpoint and the UART.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   push, din   - write din at the tail
//   pop         - advance the head; ignored while empty
//   dout        - head entry, 0 while empty
//   count       - occupancy, 0..DEPTH
module usb_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // DEPTH is a power of two, so pointer overflow is the wrap to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= din;
    end

    assign dout = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/usb_uart_out_ep.sv
// usb_uart_out_ep: drains the USB OUT endpoint buffer into a receive FIFO
// that a UART transmitter consumes.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   out_ep_req/grant      - endpoint buffer arbitration
//   out_ep_data_avail     - endpoint still holds unread bytes
//   out_ep_setup          - current packet is SETUP
//   out_ep_data_get       - pop one endpoint byte; out_ep_data valid next cycle
//   out_ep_data           - endpoint byte
//   out_ep_stall          - tied 0
//   out_ep_acked          - ignored
//   uart_re/do/ready      - FIFO pop, head byte (0 when empty), non-empty flag
// Option: USB_UART_OUT_SETUP_DROP_EN - discard SETUP bytes instead of queueing.
module usb_uart_out_ep
    import usb_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = USB_UART_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    output logic       out_ep_req,
    input  logic       out_ep_grant,
    input  logic       out_ep_data_avail,
    input  logic       out_ep_setup,
    output logic       out_ep_data_get,
    input  logic [7:0] out_ep_data,
    output logic       out_ep_stall,
    input  logic       out_ep_acked,
    input  logic       uart_re,
    output logic [7:0] uart_do,
    output logic       uart_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ep_state_t       state;
    ep_state_t       state_nxt;
    logic            get_q;       // a byte was popped last cycle and is arriving now
    logic            pending;     // in-flight byte that will land in the FIFO
    logic            push;
    logic            fifo_space;
    logic            read_space;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic            unused_acked;

    assign unused_acked = out_ep_acked;
    assign out_ep_stall = 1'b0;

    // Occupancy includes the byte still in flight so a push is never refused.
    assign occ        = count + CW'(pending);
    assign fifo_space = occ < CW'(FIFO_DEPTH);

`ifdef USB_UART_OUT_SETUP_DROP_EN
    logic get_setup_q;

    always_ff @(posedge clk) begin
        if (reset) get_setup_q <= 1'b0;
        else       get_setup_q <= out_ep_data_get && out_ep_setup;
    end

    assign pending    = get_q && !get_setup_q;
    assign push       = pending;
    assign read_space = fifo_space || out_ep_setup;
`else
    logic unused_setup;

    assign unused_setup = out_ep_setup;
    assign pending      = get_q;
    assign push         = get_q;
    assign read_space   = fifo_space;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            get_q <= 1'b0;
        end else begin
            state <= state_nxt;
            get_q <= out_ep_data_get;
        end
    end

    always_comb begin
        state_nxt       = state;
        out_ep_data_get = 1'b0;
        case (state)
            IDLE:  if (out_ep_data_avail && fifo_space) state_nxt = REQ;
            REQ:   if (out_ep_grant) state_nxt = READ;
            READ: begin
                if (out_ep_grant && out_ep_data_avail && read_space)
                    out_ep_data_get = 1'b1;
                else
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_ep_req = (state == REQ) || (state == READ);
    assign uart_ready = (count != '0);

    usb_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (uart_re),
        .din   (out_ep_data),
        .dout  (uart_do),
        .count (count)
    );

endmodule

// File: tb/tb_usb_uart_out_ep.sv
module tb_usb_uart_out_ep;

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ep_req;
    logic       out_ep_grant;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;
    logic       uart_re;
    logic [7:0] uart_do;
    logic       uart_ready;

    // Endpoint buffer model
    logic [7:0] ep_buf [16];
    int         ep_len;
    int         ep_idx;
    int         get_cnt;
    logic       ep_clr;
    logic       grant_auto;
    logic       grant_manual;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    usb_uart_out_ep #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked),
        .uart_re           (uart_re),
        .uart_do           (uart_do),
        .uart_ready        (uart_ready)
    );

    assign out_ep_data_avail = !ep_clr && (ep_idx < ep_len);
    assign out_ep_grant      = grant_auto ? out_ep_req : grant_manual;

    always @(posedge clk) begin
        if (ep_clr) begin
            ep_idx      <= 0;
            get_cnt     <= 0;
            out_ep_data <= '0;
        end else if (out_ep_data_get) begin
            out_ep_data <= ep_buf[ep_idx];
            ep_idx      <= ep_idx + 1;
            get_cnt     <= get_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_packet(input int len);
        ep_len = len;
        ep_clr = 1'b1;
        tick();
        ep_clr = 1'b0;
    endtask

    task automatic pop_one();
        uart_re = 1'b1;
        tick();
        uart_re = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_n(2);
        n_checks++; if (out_ep_req !== 1'b0) $display("FAIL rst_req: got %b want 0", out_ep_req); else n_pass++;
        n_checks++; if (out_ep_data_get !== 1'b0) $display("FAIL rst_get: got %b want 0", out_ep_data_get); else n_pass++;
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", uart_ready); else n_pass++;
        n_checks++; if (uart_do !== 8'h00) $display("FAIL rst_do: got %h want 00", uart_do); else n_pass++;
        n_checks++; if (out_ep_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", out_ep_stall); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int exp_get [7] = '{0, 0, 1, 1, 1, 0, 0};
        ep_buf[0] = 8'h41; ep_buf[1] = 8'h42; ep_buf[2] = 8'h43;
        start_packet(3);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (out_ep_data_get !== exp_get[i][0])
                $display("FAIL basic_get_c%0d: got %b want %0d", i, out_ep_data_get, exp_get[i]);
            else n_pass++;
            if (i == 3) begin
                n_checks++; if (uart_ready !== 1'b0) $display("FAIL basic_ready_early: got %b want 0", uart_ready); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (uart_ready !== 1'b1) $display("FAIL basic_ready_rise: got %b want 1", uart_ready); else n_pass++;
            end
            tick();
        end
        n_checks++; if (uart_do !== 8'h41) $display("FAIL basic_b0: got %h want 41", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_do !== 8'h42) $display("FAIL basic_b1: got %h want 42", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_do !== 8'h43) $display("FAIL basic_b2: got %h want 43", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL basic_empty: got %b want 0", uart_ready); else n_pass++;
        n_checks++; if (uart_do !== 8'h00) $display("FAIL basic_empty_do: got %h want 00", uart_do); else n_pass++;
    endtask

    task automatic test_full();
        logic seen_req;
        for (int i = 0; i < 6; i++) ep_buf[i] = 8'(8'h10 + i);
        start_packet(6);
        tick_n(20);
        n_checks++; if (get_cnt !== 4) $display("FAIL full_gets: got %0d want 4", get_cnt); else n_pass++;
        n_checks++; if (out_ep_req !== 1'b0) $display("FAIL full_req_drop: got %b want 0", out_ep_req); else n_pass++;
        n_checks++; if (uart_ready !== 1'b1) $display("FAIL full_ready: got %b want 1", uart_ready); else n_pass++;
        n_checks++; if (uart_do !== 8'h10) $display("FAIL full_b0: got %h want 10", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_do !== 8'h11) $display("FAIL full_b1: got %h want 11", uart_do); else n_pass++;
        pop_one();
        seen_req = 1'b0;
        for (int i = 0; i < 30 && get_cnt < 6; i++) begin
            if (out_ep_req) seen_req = 1'b1;
            tick();
        end
        n_checks++; if (seen_req !== 1'b1) $display("FAIL full_rereq: got %b want 1", seen_req); else n_pass++;
        n_checks++; if (get_cnt !== 6) $display("FAIL full_gets_total: got %0d want 6", get_cnt); else n_pass++;
        tick_n(4);
        for (int i = 2; i < 6; i++) begin
            n_checks++;
            if (uart_do !== 8'(8'h10 + i)) $display("FAIL full_b%0d: got %h want %h", i, uart_do, 8'(8'h10 + i));
            else n_pass++;
            pop_one();
        end
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL full_empty: got %b want 0", uart_ready); else n_pass++;
    endtask

    task automatic test_grant_delay();
        grant_auto   = 1'b0;
        grant_manual = 1'b0;
        ep_buf[0] = 8'h77;
        start_packet(1);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (out_ep_data_get !== 1'b0) $display("FAIL gdly_get_c%0d: got %b want 0", i, out_ep_data_get);
            else n_pass++;
            tick();
        end
        n_checks++; if (out_ep_req !== 1'b1) $display("FAIL gdly_req: got %b want 1", out_ep_req); else n_pass++;
        grant_manual = 1'b1;
        n_checks++; if (out_ep_data_get !== 1'b0) $display("FAIL gdly_get_grant: got %b want 0", out_ep_data_get); else n_pass++;
        tick();
        n_checks++; if (out_ep_data_get !== 1'b1) $display("FAIL gdly_get_after: got %b want 1", out_ep_data_get); else n_pass++;
        tick_n(4);
        grant_manual = 1'b0;
        grant_auto   = 1'b1;
        n_checks++; if (uart_do !== 8'h77) $display("FAIL gdly_byte: got %h want 77", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL gdly_empty: got %b want 0", uart_ready); else n_pass++;
    endtask

    task automatic test_push_pop_wrap();
        ep_buf[0] = 8'hA0; ep_buf[1] = 8'hA1; ep_buf[2] = 8'hA2;
        start_packet(3);
        tick_n(10);
        ep_buf[0] = 8'hA3;
        start_packet(1);
        tick_n(2);
        n_checks++; if (out_ep_data_get !== 1'b1) $display("FAIL wrap_get: got %b want 1", out_ep_data_get); else n_pass++;
        tick();
        // push of A3 and pop of A0 land on the same edge
        n_checks++; if (uart_do !== 8'hA0) $display("FAIL wrap_b0: got %h want a0", uart_do); else n_pass++;
        pop_one();
        tick_n(3);
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (uart_do !== 8'(8'hA0 + i)) $display("FAIL wrap_b%0d: got %h want %h", i, uart_do, 8'(8'hA0 + i));
            else n_pass++;
            pop_one();
        end
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL wrap_empty: got %b want 0", uart_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ep_buf[0] = 8'hB0; ep_buf[1] = 8'hB1;
        start_packet(2);
        tick_n(2);
        n_checks++; if (out_ep_data_get !== 1'b1) $display("FAIL rmid_get: got %b want 1", out_ep_data_get); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", uart_ready); else n_pass++;
        n_checks++; if (out_ep_req !== 1'b0) $display("FAIL rmid_req: got %b want 0", out_ep_req); else n_pass++;
        n_checks++; if (uart_do !== 8'h00) $display("FAIL rmid_do: got %h want 00", uart_do); else n_pass++;
        reset = 1'b0;
        tick_n(5);
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL rmid_no_write: got %b want 0", uart_ready); else n_pass++;
    endtask

    task automatic test_setup();
`ifdef USB_UART_OUT_SETUP_DROP_EN
        for (int i = 0; i < 8; i++) ep_buf[i] = 8'(8'h80 + i);
        out_ep_setup = 1'b1;
        start_packet(8);
        for (int i = 0; i < 40 && get_cnt < 8; i++) tick();
        tick_n(4);
        n_checks++; if (get_cnt !== 8) $display("FAIL setup_gets: got %0d want 8", get_cnt); else n_pass++;
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL setup_dropped: got %b want 0", uart_ready); else n_pass++;
        out_ep_setup = 1'b0;
        ep_buf[0] = 8'h55;
        start_packet(1);
        tick_n(8);
        n_checks++; if (get_cnt !== 1) $display("FAIL setup_data_get: got %0d want 1", get_cnt); else n_pass++;
        n_checks++; if (uart_do !== 8'h55) $display("FAIL setup_data: got %h want 55", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL setup_empty: got %b want 0", uart_ready); else n_pass++;
`else
        ep_buf[0] = 8'hC0; ep_buf[1] = 8'hC1;
        out_ep_setup = 1'b1;
        start_packet(2);
        tick_n(10);
        out_ep_setup = 1'b0;
        n_checks++; if (get_cnt !== 2) $display("FAIL setup_gets: got %0d want 2", get_cnt); else n_pass++;
        n_checks++; if (uart_do !== 8'hC0) $display("FAIL setup_b0: got %h want c0", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_do !== 8'hC1) $display("FAIL setup_b1: got %h want c1", uart_do); else n_pass++;
        pop_one();
        n_checks++; if (uart_ready !== 1'b0) $display("FAIL setup_empty: got %b want 0", uart_ready); else n_pass++;
`endif
    endtask

    initial begin
        reset        = 1'b1;
        uart_re      = 1'b0;
        ep_clr       = 1'b1;
        ep_len       = 0;
        grant_auto   = 1'b1;
        grant_manual = 1'b0;
        out_ep_setup = 1'b0;
        out_ep_acked = 1'b0;
        for (int i = 0; i < 16; i++) ep_buf[i] = '0;
        test_reset();
        ep_clr = 1'b0;
        test_basic();
        test_full();
        test_grant_delay();
        test_push_pop_wrap();
        test_reset_mid();
        test_setup();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
